// File: rtl/led_matrix_scan.sv
// led_matrix_scan: 4x4 LED matrix row scanner with 16-level PWM per pixel.
// A shadow buffer is written through wr_*; commit copies it into the active
// buffer just before row 0 (or at once when idle) so frames never tear.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              scan enable (level)
//   wr_en/addr/data     shadow-buffer write port, addr = {row, col}
//   commit              request shadow -> active copy
//   aled                one-hot anode drive for the scanned row
//   kled_oe             per-column cathode enable, 0 = pixel lit
//   row                 row currently scanned
//   frame_start         pulse on the first ON cycle of row 0
//   commit_pending      a commit is waiting for its copy slot
module led_matrix_scan #(
    parameter int unsigned SLOT_CYC  = 4,
    parameter int unsigned BLANK_CYC = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       commit,
    output logic [3:0] aled,
    output logic [3:0] kled_oe,
    output logic [1:0] row,
    output logic       frame_start,
    output logic       commit_pending
);

    localparam int unsigned BLANK_W = $clog2(BLANK_CYC + 1);
    localparam int unsigned SUB_W   = $clog2(SLOT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_t;

    state_t             state, state_nx;
    logic [BLANK_W-1:0] blank_cnt, blank_cnt_nx;
    logic [SUB_W-1:0]   sub_cnt, sub_cnt_nx;
    logic [3:0]         slot, slot_nx;
    logic [1:0]         row_nx;
    logic               pend_nx;
    logic               copy;
    logic               blank_last;
    logic               sub_last;
    logic [3:0]         aled_nx;
    logic [3:0]         kled_nx;
    logic               fs_nx;

    logic [3:0] shadow [16];
    logic [3:0] active [16];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            row            <= 2'd0;
            blank_cnt      <= '0;
            sub_cnt        <= '0;
            slot           <= 4'd0;
            commit_pending <= 1'b0;
        end else begin
            state          <= state_nx;
            row            <= row_nx;
            blank_cnt      <= blank_cnt_nx;
            sub_cnt        <= sub_cnt_nx;
            slot           <= slot_nx;
            commit_pending <= pend_nx;
        end
    end

    // Next-state, scan counters and commit handling
    always_comb begin
        state_nx     = state;
        row_nx       = row;
        blank_cnt_nx = blank_cnt;
        sub_cnt_nx   = sub_cnt;
        slot_nx      = slot;
        blank_last   = (blank_cnt == BLANK_W'(BLANK_CYC - 1));
        sub_last     = (sub_cnt == SUB_W'(SLOT_CYC - 1));

        case (state)
            S_IDLE: begin
                row_nx = 2'd0;
                if (enable) begin
                    state_nx     = S_BLANK;
                    blank_cnt_nx = '0;
                end
            end
            S_BLANK: begin
                if (!enable) begin
                    state_nx = S_IDLE;
                    row_nx   = 2'd0;
                end else if (blank_last) begin
                    state_nx   = S_ON;
                    sub_cnt_nx = '0;
                    slot_nx    = 4'd0;
                end else begin
                    blank_cnt_nx = blank_cnt + BLANK_W'(1);
                end
            end
            S_ON: begin
                if (!enable) begin
                    state_nx = S_IDLE;
                    row_nx   = 2'd0;
                end else if (sub_last) begin
                    sub_cnt_nx = '0;
                    if (slot == 4'd15) begin
                        state_nx     = S_BLANK;
                        blank_cnt_nx = '0;
                        row_nx       = row + 2'd1;
                    end else begin
                        slot_nx = slot + 4'd1;
                    end
                end else begin
                    sub_cnt_nx = sub_cnt + SUB_W'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
                row_nx   = 2'd0;
            end
        endcase

        // Copy slot: anytime while idle, else the last blank cycle before row 0
        copy    = commit_pending &&
                  ((state == S_IDLE) ||
                   ((state == S_BLANK) && enable && blank_last && (row == 2'd0)));
        pend_nx = copy ? 1'b0 : (commit_pending | commit);
    end

    // Output decode from next state; pixels come from shadow on the copy edge
    always_comb begin
        aled_nx = 4'd0;
        kled_nx = 4'hF;
        fs_nx   = 1'b0;
        if (state_nx == S_ON) begin
            aled_nx = 4'd1 << row_nx;
            for (int c = 0; c < 4; c++) begin
                kled_nx[c] = ((copy ? shadow[{row_nx, 2'(c)}] : active[{row_nx, 2'(c)}])
                              <= slot_nx);
            end
            fs_nx = (state == S_BLANK) && (row_nx == 2'd0);
        end
    end

    // Registered drive outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aled        <= 4'd0;
            kled_oe     <= 4'hF;
            frame_start <= 1'b0;
        end else begin
            aled        <= aled_nx;
            kled_oe     <= kled_nx;
            frame_start <= fs_nx;
        end
    end

    // Shadow and active pixel buffers; the copy sees the pre-write shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                shadow[i] <= 4'd0;
                active[i] <= 4'd0;
            end
        end else begin
            if (wr_en) begin
                shadow[wr_addr] <= wr_data;
            end
            if (copy) begin
                for (int i = 0; i < 16; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Testbench for led_matrix_scan: directed scenarios plus random traffic,
// compared every cycle against a time-position model of the scan.
module tb_led_matrix_scan;

    localparam int SLOT   = 4;
    localparam int BLANK  = 8;
    localparam int PERIOD = BLANK + 16 * SLOT;
    localparam int FRAME  = 4 * PERIOD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [3:0] wr_data = 4'd0;
    logic       commit = 1'b0;
    logic [3:0] aled;
    logic [3:0] kled_oe;
    logic [1:0] row;
    logic       frame_start;
    logic       commit_pending;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    led_matrix_scan #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit         (commit),
        .aled           (aled),
        .kled_oe        (kled_oe),
        .row            (row),
        .frame_start    (frame_start),
        .commit_pending (commit_pending)
    );

    wire [11:0] dut_vec = {aled, kled_oe, row, frame_start, commit_pending};

    // Reference model: scanning flag, position within the row period, row index
    bit         m_scan;
    int         m_pos;
    int         m_row;
    bit         m_pend;
    bit         m_copy;
    logic [3:0] m_sh  [16];
    logic [3:0] m_act [16];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_scan = 0; m_pos = 0; m_row = 0; m_pend = 0;
            for (int i = 0; i < 16; i++) begin m_sh[i] = 0; m_act[i] = 0; end
        end else begin
            m_copy = m_pend && (!m_scan || (enable && m_pos == BLANK - 1 && m_row == 0));
            if (m_copy) for (int i = 0; i < 16; i++) m_act[i] = m_sh[i];
            m_pend = m_copy ? 1'b0 : (m_pend | commit);
            if (wr_en) m_sh[wr_addr] = wr_data;
            if (!m_scan) begin
                if (enable) begin m_scan = 1; m_pos = 0; end
                m_row = 0;
            end else if (!enable) begin
                m_scan = 0; m_row = 0;
            end else begin
                m_pos++;
                if (m_pos == PERIOD) begin m_pos = 0; m_row = (m_row + 1) % 4; end
            end
        end
    end

    function automatic logic [11:0] exp_vec();
        logic [3:0] a;
        logic [3:0] k;
        logic       fs;
        int         kk;
        a = 4'd0; k = 4'hF; fs = 1'b0;
        if (m_scan && m_pos >= BLANK) begin
            kk = (m_pos - BLANK) / SLOT;
            a  = 4'(1 << m_row);
            for (int c = 0; c < 4; c++)
                if (int'(m_act[m_row * 4 + c]) > kk) k[c] = 1'b0;
            fs = (m_row == 0) && (m_pos == BLANK);
        end
        return {a, k, 2'(m_row), fs, m_pend};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0;
        #12;
        total++;
        if (dut_vec !== 12'h0F0) $display("FAIL reset_state: got %h want %h", dut_vec, 12'h0F0);
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec());
        else passed++;
    endtask

    task automatic test_blank_scan();
        int last_fs = -1;
        int fs_bad  = 0;
        int n_fs    = 0;
        int vec_bad = 0;
        @(negedge clk); enable = 1'b1;
        for (int i = 0; i < 2 * FRAME + 20; i++) begin
            @(negedge clk);
            if (dut_vec !== exp_vec()) begin
                vec_bad++;
                if (vec_bad < 4) $display("FAIL blank_scan_vec: cycle %0d got %h want %h", i, dut_vec, exp_vec());
            end
            if ($countones(aled) > 1 || kled_oe !== 4'hF) fs_bad++;
            if (frame_start) begin
                if (last_fs >= 0 && i - last_fs != FRAME) fs_bad++;
                last_fs = i; n_fs++;
            end
        end
        total++;
        if (vec_bad != 0) $display("FAIL blank_scan_model: got %0d bad cycles want 0", vec_bad);
        else passed++;
        total++;
        if (fs_bad != 0 || n_fs != 3) $display("FAIL blank_scan_period: got %0d errs %0d pulses want 0 errs 3 pulses", fs_bad, n_fs);
        else passed++;
        enable = 1'b0;
    endtask

    task automatic test_single_pixel();
        int rel = 0;
        int stray = 0;
        int vec_bad = 0;
        @(negedge clk); wr_en = 1'b1; wr_addr = 4'd5; wr_data = 4'd8;
        @(negedge clk); wr_en = 1'b0; commit = 1'b1;
        @(negedge clk); commit = 1'b0;
        total++;
        if (commit_pending !== 1'b1) $display("FAIL idle_commit_pending: got %b want 1", commit_pending);
        else passed++;
        @(negedge clk);
        total++;
        if (commit_pending !== 1'b0) $display("FAIL idle_commit_clear: got %b want 0", commit_pending);
        else passed++;
        enable = 1'b1;
        for (int i = 0; i < FRAME + 10; i++) begin
            @(negedge clk);
            if (dut_vec !== exp_vec()) vec_bad++;
            if (aled == 4'b0010 && kled_oe == 4'b1101) rel++;
            else if (kled_oe !== 4'hF) stray++;
        end
        total++;
        if (rel != 32 || stray != 0) $display("FAIL single_pixel: got %0d release %0d stray want 32 0", rel, stray);
        else passed++;
        total++;
        if (vec_bad != 0) $display("FAIL single_pixel_model: got %0d bad cycles want 0", vec_bad);
        else passed++;
    endtask

    task automatic test_midframe_commit();
        int  rel = 0;
        int  vec_bad = 0;
        bit  seen_fs = 0;
        bit  pend_prev;
        int  i;
        for (i = 0; i < 2 * FRAME && !(row == 2'd2 && aled == 4'b0100); i++) @(negedge clk);
        total++;
        if (!(row == 2'd2 && aled == 4'b0100)) $display("FAIL midframe_wait_row2: got row %0d want 2", row);
        else passed++;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'd15;
        @(negedge clk); wr_en = 1'b0; commit = 1'b1;
        @(negedge clk); commit = 1'b0;
        pend_prev = commit_pending;
        total++;
        if (commit_pending !== 1'b1) $display("FAIL midframe_pending: got %b want 1", commit_pending);
        else passed++;
        for (i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (dut_vec !== exp_vec()) vec_bad++;
            if (frame_start && !seen_fs) begin
                seen_fs = 1;
                total++;
                if (!(pend_prev == 1'b1 && commit_pending == 1'b0))
                    $display("FAIL midframe_pending_clear: got prev %b now %b want 1 0", pend_prev, commit_pending);
                else passed++;
            end
            if (!seen_fs && commit_pending !== 1'b1) vec_bad++;
            if (seen_fs && aled == 4'b0001 && kled_oe[0] == 1'b0) rel++;
            if (seen_fs && row == 2'd1) break;
            pend_prev = commit_pending;
        end
        total++;
        if (rel != 60) $display("FAIL midframe_release: got %0d want 60", rel);
        else passed++;
        total++;
        if (vec_bad != 0 || !seen_fs) $display("FAIL midframe_model: got %0d bad fs %b want 0 1", vec_bad, seen_fs);
        else passed++;
    endtask

    task automatic test_disable();
        int n = 0;
        int i;
        for (i = 0; i < 2 * FRAME && !(aled == 4'b1000 && row == 2'd3); i++) @(negedge clk);
        repeat (10) @(negedge clk);
        total++;
        if (aled !== 4'b1000) $display("FAIL disable_wait_row3: got %b want 1000", aled);
        else passed++;
        enable = 1'b0;
        @(negedge clk);
        total++;
        if ({aled, kled_oe, row, frame_start} !== 11'b0000_1111_00_0)
            $display("FAIL disable_off: got %h want %h", {aled, kled_oe, row, frame_start}, 11'b0000_1111_00_0);
        else passed++;
        enable = 1'b1;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (frame_start || aled !== 4'd0) break;
        end
        total++;
        if (!(n == BLANK + 1 && frame_start && aled == 4'b0001))
            $display("FAIL disable_restart: got %0d cycles aled %b want %0d 0001", n, aled, BLANK + 1);
        else passed++;
        total++;
        if (dut_vec !== exp_vec()) $display("FAIL disable_model: got %h want %h", dut_vec, exp_vec());
        else passed++;
    endtask

    task automatic test_random();
        int vec_bad = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (dut_vec !== exp_vec()) begin
                vec_bad++;
                if (vec_bad < 4) $display("FAIL random_vec: cycle %0d got %h want %h", i, dut_vec, exp_vec());
            end
            wr_en   = ($urandom % 4) == 0;
            wr_addr = 4'($urandom);
            wr_data = 4'($urandom);
            commit  = ($urandom % 64) == 0;
            if (($urandom % 400) == 0) enable = ~enable;
        end
        wr_en = 1'b0; commit = 1'b0;
        total++;
        if (vec_bad != 0) $display("FAIL random_model: got %0d bad cycles want 0", vec_bad);
        else passed++;
    endtask

    task automatic test_async_reset();
        int lit = 0;
        int vec_bad = 0;
        int n_fs = 0;
        int i;
        @(negedge clk); enable = 1'b0;
        for (i = 0; i < 4; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_addr = 4'(i); wr_data = 4'd15;
        end
        @(negedge clk); wr_en = 1'b0; commit = 1'b1;
        @(negedge clk); commit = 1'b0; enable = 1'b1;
        for (i = 0; i < 2 * FRAME && !(aled == 4'b0001 && kled_oe == 4'h0); i++) @(negedge clk);
        total++;
        if (kled_oe !== 4'h0) $display("FAIL areset_lit: got %h want 0", kled_oe);
        else passed++;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        total++;
        if ({aled, kled_oe, row, frame_start, commit_pending} !== 12'h0F0)
            $display("FAIL areset_immediate: got %h want %h", {aled, kled_oe, row, frame_start, commit_pending}, 12'h0F0);
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        for (i = 0; i < FRAME + 10; i++) begin
            @(negedge clk);
            if (dut_vec !== exp_vec()) vec_bad++;
            if (aled !== 4'd0 && kled_oe !== 4'hF) lit++;
            if (frame_start) n_fs++;
        end
        total++;
        if (lit != 0 || n_fs == 0) $display("FAIL areset_buffers_zero: got %0d lit %0d frames want 0 >0", lit, n_fs);
        else passed++;
        total++;
        if (vec_bad != 0) $display("FAIL areset_model: got %0d bad cycles want 0", vec_bad);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_blank_scan();
        test_single_pixel();
        test_midframe_commit();
        test_disable();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/led_matrix_scan.md
LED_MATRIX_SCAN -- requirements
Module: led_matrix_scan

Interface
REQ-001 SHALL have parameter SLOT_CYC, default 4, clock cycles per PWM slot (>=1).
REQ-002 SHALL have parameter BLANK_CYC, default 8, dead-time cycles between rows (>=1).
REQ-003 SHALL have port clk  in  1  single clock, 48 MHz internal oscillator domain; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port enable  in  1  scan enable, level.
REQ-006 SHALL have port wr_en  in  1  shadow-buffer write strobe.
REQ-007 SHALL have port wr_addr  in  4  pixel index {row[1:0], col[1:0]}.
REQ-008 SHALL have port wr_data  in  4  pixel brightness, 0 = off, 15 = 15/16 duty.
REQ-009 SHALL have port commit  in  1  single-cycle request to copy the shadow buffer into the active buffer.
REQ-010 SHALL have port aled  out  4  anode drive, one-hot active-high, one bit per row.
REQ-011 SHALL have port kled_oe  out  4  cathode output enable per column; 1 = cathode driven high (pixel off), 0 = released (pixel on).
REQ-012 SHALL have port row  out  2  index of the row currently scanned.
REQ-013 SHALL have port frame_start  out  1  one-cycle pulse on entry to row 0 ON.
REQ-014 SHALL have port commit_pending  out  1  high from commit accepted until the copy is done.

Function
REQ-015 SHALL hold two 16x4 buffers: shadow (written via wr_*) and active (drives outputs); shadow writes take effect one cycle after wr_en.
REQ-016 SHALL implement states IDLE, BLANK and ON; all outputs registered.
REQ-017 IDLE: aled=0, kled_oe=4'hF, row=0; enable=1 -> BLANK with row=0 next cycle.
REQ-018 BLANK: aled=0, kled_oe=4'hF for exactly BLANK_CYC cycles, then -> ON.
REQ-019 ON: aled=one-hot(row); 16 slots k=0..15 of SLOT_CYC cycles each (16*SLOT_CYC cycles total); kled_oe[c]=0 in slot k iff active[row][c] > k, else 1.
REQ-020 End of ON: row wraps 3->0 (modulo 4) and -> BLANK; row period = BLANK_CYC+16*SLOT_CYC cycles, frame = 4 rows.
REQ-021 frame_start SHALL pulse in the first ON cycle of row 0 only.
REQ-022 Commit: on commit=1, commit_pending SHALL go 1 the next cycle; the shadow->active copy SHALL occur in the last BLANK cycle before row 0 ON (or immediately in IDLE); commit_pending SHALL clear in the cycle after the copy.
REQ-023 Further commits while commit_pending=1 SHALL merge into the pending one; a wr_en in the copy cycle SHALL update shadow only, never active.
REQ-024 enable=0 in BLANK or ON: next cycle -> IDLE, aled=0, kled_oe=4'hF, row=0; the pending commit SHALL be retained and executed in IDLE.
REQ-025 SHALL never assert two aled bits at once, nor any aled bit during BLANK or IDLE.
REQ-026 Brightness 0 SHALL keep kled_oe[c]=1 for the whole ON phase; 15 SHALL give exactly 15*SLOT_CYC release cycles.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, aled=0, kled_oe=4'hF, row=0, frame_start=0, commit_pending=0, all buffer entries 0.
REQ-028 After rst_n rises, the first scan SHALL start on the first rising clk edge with enable=1.
REQ-029 Reset asserted mid-ON SHALL extinguish all anodes without waiting for a clock edge.

Verification (SLOT_CYC=4, BLANK_CYC=8: row 72 cycles, frame 288)
REQ-030 Reset, enable=1, all pixels 0 -> aled walks 0001,0010,0100,1000 with 64-cycle ON and 8-cycle gaps; kled_oe stays F; frame_start period 288 cycles.
REQ-031 Write addr 5 (row1,col1)=8, commit in IDLE, enable -> kled_oe[1]=0 for the first 32 ON cycles of row 1 only, then 1.
REQ-032 Write 15 to addr 0 and commit mid-frame (row 2) -> commit_pending=1 until the copy in the last BLANK cycle before row 0; new value visible from the next frame_start; 60 release cycles.
REQ-033 Drop enable mid-ON in row 3 -> outputs off the next cycle, row=0; re-enable -> 8 BLANK cycles, then row 0 with frame_start.
REQ-034 Assert rst_n=0 asynchronously mid-ON -> aled=0 before the next clk edge; buffers read back 0 afterwards.
